// File: rtl/frame_ram_arbiter_if.sv
// Bundle of every signal between the frame RAM arbiter, its two clients and the frame RAM.
// Ports: display fetch (disp_*), game port (gp_*), status (addr_err, stall_cnt), RAM side (ram_*).
interface frame_ram_arbiter_if #(
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 4,
    parameter int STALL_W = 16
);
    logic               disp_req;
    logic [ADDR_W-1:0]  disp_addr;
    logic [DATA_W-1:0]  disp_data;
    logic               disp_valid;

    logic               gp_valid;
    logic               gp_ready;
    logic               gp_we;
    logic [ADDR_W-1:0]  gp_addr;
    logic [DATA_W-1:0]  gp_wdata;
    logic [DATA_W-1:0]  gp_rdata;
    logic               gp_rvalid;

    logic               addr_err;
    logic [STALL_W-1:0] stall_cnt;

    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_we;
    logic [DATA_W-1:0]  ram_wdata;
    logic [DATA_W-1:0]  ram_rdata;

    // Arbiter side.
    modport slave (
        input  disp_req, disp_addr,
        output disp_data, disp_valid,
        input  gp_valid, gp_we, gp_addr, gp_wdata,
        output gp_ready, gp_rdata, gp_rvalid,
        output addr_err, stall_cnt,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    // Client / RAM side.
    modport master (
        output disp_req, disp_addr,
        input  disp_data, disp_valid,
        output gp_valid, gp_we, gp_addr, gp_wdata,
        input  gp_ready, gp_rdata, gp_rvalid,
        input  addr_err, stall_cnt,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/frame_ram_arbiter.sv
// Shares the single frame RAM port between VGA scan-out (absolute priority) and a game port.
// Ports: Clk, Reset_n (async, active low), bus (frame_ram_arbiter_if.slave: disp_*, gp_*, status, ram_*).
module frame_ram_arbiter #(
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 4,
    parameter int DEPTH   = 307200,
    parameter int STALL_W = 16
) (
    input  logic                Clk,
    input  logic                Reset_n,
    frame_ram_arbiter_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t              state;
    logic                hold_we;
    logic                hold_oor;
    logic [ADDR_W-1:0]   hold_addr;
    logic [DATA_W-1:0]   hold_wdata;
    logic                rd_valid;
    logic                rd_oor;
    logic                disp_q;
    logic                err_q;
    logic [STALL_W-1:0]  stall_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            hold_we    <= 1'b0;
            hold_oor   <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            rd_valid   <= 1'b0;
            rd_oor     <= 1'b0;
            disp_q     <= 1'b0;
            err_q      <= 1'b0;
            stall_q    <= '0;
        end else begin
            disp_q   <= bus.disp_req;
            rd_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.gp_valid) begin
                        hold_we    <= bus.gp_we;
                        hold_addr  <= bus.gp_addr;
                        hold_wdata <= bus.gp_wdata;
                        hold_oor   <= (bus.gp_addr >= LIMIT);
                        if (bus.gp_addr >= LIMIT) begin
                            err_q <= 1'b1;
                        end
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.disp_req) begin
                        if (stall_q != '1) begin
                            stall_q <= stall_q + 1'b1;
                        end
                    end else begin
                        // Reads (even out-of-range ones) take this slot
                        // and answer on the cycle the RAM output is valid.
                        rd_valid <= !hold_we;
                        rd_oor   <= hold_oor;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = '0;
        if (bus.disp_req) begin
            bus.ram_addr = bus.disp_addr;
        end else if (state == HOLD && !hold_oor) begin
            bus.ram_addr  = hold_addr;
            bus.ram_we    = hold_we;
            bus.ram_wdata = hold_wdata;
        end
    end

    assign bus.gp_ready   = (state == IDLE);
    assign bus.disp_valid = disp_q;
    assign bus.disp_data  = bus.ram_rdata;
    // The RAM output is already registered; an out-of-range read
    // masks it so the requester sees zero.
    assign bus.gp_rvalid  = rd_valid;
    assign bus.gp_rdata   = (rd_valid && !rd_oor) ? bus.ram_rdata : '0;
    assign bus.addr_err   = err_q;
    assign bus.stall_cnt  = stall_q;
endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed bench for frame_ram_arbiter with a frame RAM model and read-data scoreboard.
// Ports: none (top-level bench).
module tb_frame_ram_arbiter;
    localparam int AW = 19;
    localparam int DW = 4;
    localparam int DEPTH = 307200;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    frame_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .STALL_W(16)) bus ();
    frame_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .STALL_W(4))  bus4 ();

    frame_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .STALL_W(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave)
    );
    frame_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .STALL_W(4)) dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus4.slave)
    );

    assign bus4.ram_rdata = '0;

    logic [DW-1:0] mem   [0:DEPTH-1];
    logic [DW-1:0] model [0:DEPTH-1];
    logic [DW-1:0] disp_exp[$];
    logic [DW-1:0] gp_exp[$];
    int passed = 0;
    int total = 0;
    int exp_stall = 0;

    // Registered single-port frame RAM.
    always @(posedge Clk) begin
        if (int'(bus.ram_addr) < DEPTH) begin
            bus.ram_rdata <= mem[bus.ram_addr];
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        end else begin
            bus.ram_rdata <= '0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic disp(input int a);
        bus.disp_req  = 1'b1;
        bus.disp_addr = AW'(a);
        disp_exp.push_back(model[a]);
    endtask

    task automatic gp(input logic we, input int a, input logic [DW-1:0] d);
        bus.gp_valid = 1'b1;
        bus.gp_we    = we;
        bus.gp_addr  = AW'(a);
        bus.gp_wdata = d;
    endtask

    // Scoreboard: pop expected data whenever a response appears.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (bus.disp_valid) begin
                check("disp_pending", 32'(disp_exp.size() != 0), 1);
                if (disp_exp.size() != 0) check("disp_data", 32'(bus.disp_data), 32'(disp_exp.pop_front()));
            end
            if (bus.gp_rvalid) begin
                check("gp_pending", 32'(gp_exp.size() != 0), 1);
                if (gp_exp.size() != 0) check("gp_rdata", 32'(bus.gp_rdata), 32'(gp_exp.pop_front()));
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]   = DW'(i * 7 + 3);
            model[i] = DW'(i * 7 + 3);
        end
        mem[5]   = 4'hA;
        model[5] = 4'hA;
        bus.disp_req = 0; bus.disp_addr = '0;
        bus.gp_valid = 0; bus.gp_we = 0; bus.gp_addr = '0; bus.gp_wdata = '0;
        bus4.disp_req = 0; bus4.disp_addr = '0;
        bus4.gp_valid = 0; bus4.gp_we = 0; bus4.gp_addr = '0; bus4.gp_wdata = '0;

        // Reset state
        repeat (3) step();
        check("rst_gp_ready", 32'(bus.gp_ready), 1);
        check("rst_disp_valid", 32'(bus.disp_valid), 0);
        check("rst_gp_rvalid", 32'(bus.gp_rvalid), 0);
        check("rst_gp_rdata", 32'(bus.gp_rdata), 0);
        check("rst_addr_err", 32'(bus.addr_err), 0);
        check("rst_stall", 32'(bus.stall_cnt), 0);
        check("rst_ram_we", 32'(bus.ram_we), 0);
        Reset_n = 1'b1;
        step();

        // 1: idle read of addr 5
        step(); gp(0, 5, 0); #1;
        check("t1_ready", 32'(bus.gp_ready), 1);
        gp_exp.push_back(model[5]);
        step(); bus.gp_valid = 0; #1;
        check("t1_issue_addr", 32'(bus.ram_addr), 5);
        check("t1_issue_we", 32'(bus.ram_we), 0);
        check("t1_busy", 32'(bus.gp_ready), 0);
        step(); #1;
        check("t1_rvalid", 32'(bus.gp_rvalid), 1);
        check("t1_ready_again", 32'(bus.gp_ready), 1);
        step(); #1;
        check("t1_rvalid_pulse", 32'(bus.gp_rvalid), 0);

        // 2: write held behind 10 display cycles
        step(); gp(1, 100, 4'h3);
        for (int i = 0; i < 10; i++) begin
            step(); bus.gp_valid = 0; disp(200 + i); #1;
            check("t2_no_we", 32'(bus.ram_we), 0);
            check("t2_disp_addr", 32'(bus.ram_addr), 32'(200 + i));
        end
        step(); bus.disp_req = 0; #1;
        check("t2_we", 32'(bus.ram_we), 1);
        check("t2_addr", 32'(bus.ram_addr), 100);
        check("t2_wdata", 32'(bus.ram_wdata), 3);
        model[100] = 4'h3;
        exp_stall += 10;
        check("t2_stall", 32'(bus.stall_cnt), 32'(exp_stall));
        step(); gp(0, 100, 0); gp_exp.push_back(model[100]);
        step(); bus.gp_valid = 0;
        step(); step();

        // 3: display stream over one line with a read held
        step(); gp(0, 7, 0); gp_exp.push_back(model[7]); disp(0);
        for (int a = 1; a < 640; a++) begin
            step(); bus.gp_valid = 0; disp(a); #1;
            check("t3_ready_low", 32'(bus.gp_ready), 0);
        end
        step(); bus.disp_req = 0; #1;
        check("t3_issue_addr", 32'(bus.ram_addr), 7);
        exp_stall += 639;
        check("t3_stall", 32'(bus.stall_cnt), 32'(exp_stall));
        step(); step();

        // 4: out-of-range write and read
        step(); gp(1, 307200, 4'h5);
        step(); bus.gp_valid = 0; #1;
        check("t4_addr_err", 32'(bus.addr_err), 1);
        check("t4_no_we", 32'(bus.ram_we), 0);
        check("t4_busy", 32'(bus.gp_ready), 0);
        step(); gp(0, 307300, 0); gp_exp.push_back(4'h0);
        step(); bus.gp_valid = 0; #1;
        check("t4_rd_we", 32'(bus.ram_we), 0);
        check("t4_rd_addr", 32'(bus.ram_addr), 0);
        step(); #1;
        check("t4_rvalid", 32'(bus.gp_rvalid), 1);
        check("t4_rdata", 32'(bus.gp_rdata), 0);
        step();

        // 5: reset while a read is held
        step(); gp(0, 9, 0);
        step(); bus.gp_valid = 0; bus.disp_req = 1; bus.disp_addr = AW'(9); #1;
        check("t5_held", 32'(bus.gp_ready), 0);
        Reset_n = 1'b0; bus.disp_req = 0; #1;
        check("t5_rst_ready", 32'(bus.gp_ready), 1);
        check("t5_rst_stall", 32'(bus.stall_cnt), 0);
        check("t5_rst_err", 32'(bus.addr_err), 0);
        check("t5_rst_dvalid", 32'(bus.disp_valid), 0);
        check("t5_rst_rvalid", 32'(bus.gp_rvalid), 0);
        check("t5_rst_we", 32'(bus.ram_we), 0);
        step(); step();
        Reset_n = 1'b1;
        exp_stall = 0;
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            check("t5_no_rvalid", 32'(bus.gp_rvalid), 0);
            check("t5_ready", 32'(bus.gp_ready), 1);
        end

        // 6: 4-bit stall counter saturates
        step(); bus4.gp_valid = 1; bus4.gp_we = 1; bus4.gp_addr = AW'(1); bus4.gp_wdata = 4'h9;
        for (int i = 0; i < 20; i++) begin
            step(); bus4.gp_valid = 0; bus4.disp_req = 1; bus4.disp_addr = AW'(2);
        end
        step(); bus4.disp_req = 0; #1;
        check("t6_stall_sat", 32'(bus4.stall_cnt), 15);
        check("t6_we", 32'(bus4.ram_we), 1);
        step();

        for (int i = 0; i < 20 && (disp_exp.size() + gp_exp.size()) != 0; i++) step();
        check("drain", 32'(disp_exp.size() + gp_exp.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
